// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for
//               an RV32I datapath with memory handshake supervision and traps.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear_trap,
    input  logic [6:0]           opcode,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 ir_en,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 reg_write_en,
    output logic                 pc_en,
    output logic                 halted,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_DECODE    = 3'd2;
    localparam logic [2:0] c_EXECUTE   = 3'd3;
    localparam logic [2:0] c_MEMORY    = 3'd4;
    localparam logic [2:0] c_WRITEBACK = 3'd5;
    localparam logic [2:0] c_TRAP      = 3'd6;

    localparam logic [1:0] c_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] c_CAUSE_DMEM_TO = 2'b11;

    localparam logic [6:0] c_OP_LOAD   = 7'h03;
    localparam logic [6:0] c_OP_STORE  = 7'h23;
    localparam logic [6:0] c_OP_BRANCH = 7'h63;

    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_wait_cnt;
    logic [1:0]           r_trap_cause;
    logic [INSTRET_W-1:0] r_instret;

    logic [2:0] w_next;
    logic [2:0] w_boundary;
    logic [1:0] w_cause_new;
    logic       w_legal;
    logic       w_expired;
    logic       w_imem_req;
    logic       w_ir_en;
    logic       w_dmem_req;
    logic       w_dmem_we;
    logic       w_reg_write_en;
    logic       w_pc_en;

    always_comb begin
        case (opcode)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h67, 7'h6F, 7'h17, 7'h37: w_legal = 1'b1;
            default:                    w_legal = 1'b0;
        endcase
    end

    assign w_boundary = run ? c_FETCH : c_IDLE;
    assign w_expired  = (r_wait_cnt == c_CNT_LAST);

    always_comb begin
        w_next         = r_state;
        w_cause_new    = c_CAUSE_NONE;
        w_imem_req     = 1'b0;
        w_ir_en        = 1'b0;
        w_dmem_req     = 1'b0;
        w_dmem_we      = 1'b0;
        w_reg_write_en = 1'b0;
        w_pc_en        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (run) w_next = c_FETCH;
            end
            c_FETCH: begin
                w_imem_req = 1'b1;
                // An ack arriving in the expiry cycle still counts as success.
                if (imem_ack) begin
                    w_ir_en = 1'b1;
                    w_next  = c_DECODE;
                end else if (w_expired) begin
                    w_next      = c_TRAP;
                    w_cause_new = c_CAUSE_IMEM_TO;
                end
            end
            c_DECODE: begin
                if (w_legal) begin
                    w_next = c_EXECUTE;
                end else begin
                    w_next      = c_TRAP;
                    w_cause_new = c_CAUSE_ILLEGAL;
                end
            end
            c_EXECUTE: begin
                if (opcode == c_OP_LOAD || opcode == c_OP_STORE) begin
                    w_next = c_MEMORY;
                end else if (opcode == c_OP_BRANCH) begin
                    w_pc_en = 1'b1;
                    w_next  = w_boundary;
                end else begin
                    w_next = c_WRITEBACK;
                end
            end
            c_MEMORY: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (opcode == c_OP_STORE);
                if (dmem_ack) begin
                    if (opcode == c_OP_STORE) begin
                        w_pc_en = 1'b1;
                        w_next  = w_boundary;
                    end else begin
                        w_next = c_WRITEBACK;
                    end
                end else if (w_expired) begin
                    w_next      = c_TRAP;
                    w_cause_new = c_CAUSE_DMEM_TO;
                end
            end
            c_WRITEBACK: begin
                w_reg_write_en = 1'b1;
                w_pc_en        = 1'b1;
                w_next         = w_boundary;
            end
            c_TRAP: begin
                if (clear_trap) w_next = c_IDLE;
            end
            default: begin
                w_next      = c_TRAP;
                w_cause_new = c_CAUSE_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wait_cnt   <= '0;
            r_trap_cause <= c_CAUSE_NONE;
            r_instret    <= '0;
        end else begin
            r_state <= w_next;

            if (w_next == c_TRAP && r_state != c_TRAP) begin
                r_trap_cause <= w_cause_new;
            end else if (r_state == c_TRAP && clear_trap) begin
                r_trap_cause <= c_CAUSE_NONE;
            end

            // Counter is zero outside the wait states and on ack, so every
            // entry into FETCH/MEMORY starts a fresh count.
            if ((w_imem_req && !imem_ack) || (w_dmem_req && !dmem_ack)) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_pc_en) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
        end
    end

    assign imem_req     = w_imem_req;
    assign ir_en        = w_ir_en;
    assign dmem_req     = w_dmem_req;
    assign dmem_we      = w_dmem_we;
    assign reg_write_en = w_reg_write_en;
    assign pc_en        = w_pc_en;
    assign halted       = (r_state == c_TRAP);
    assign trap_cause   = r_trap_cause;
    assign state        = r_state;
    assign instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Randomized scoreboard bench for instruction_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instruction_sequencer;

    localparam int c_T  = 4;
    localparam int c_IW = 8;

    logic            clk = 1'b0;
    logic            rst, run, clear_trap;
    logic [6:0]      opcode;
    logic            imem_ack, dmem_ack;
    logic            imem_req, ir_en, dmem_req, dmem_we, reg_write_en, pc_en, halted;
    logic [1:0]      trap_cause;
    logic [2:0]      state;
    logic [c_IW-1:0] instret;

    instruction_sequencer #(.TIMEOUT_CYCLES(c_T), .INSTRET_W(c_IW)) dut (
        .clk(clk), .rst(rst), .run(run), .clear_trap(clear_trap), .opcode(opcode),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_en(ir_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write_en(reg_write_en),
        .pc_en(pc_en), .halted(halted), .trap_cause(trap_cause), .state(state),
        .instret(instret)
    );

    always #5 clk = ~clk;

    // kind 0 = retire event, kind 1 = trap entry event
    typedef struct {
        int kind;
        int rw;
        int st;
        int cause;
        int lat;
        int instret;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   done   = 0;
    int   model_instret = 0;
    int   i_delay = 0, d_delay = 0;
    int   i_cnt = 0, d_cnt = 0;
    logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outcome and cycle cost of one instruction from its
    // opcode class and the number of wait cycles before each memory ack.
    function automatic exp_t model(input int op, input int iw, input int dw, input int cnt);
        exp_t e;
        bit   legal;
        legal = 1'b0;
        foreach (legal_ops[k]) if (int'(legal_ops[k]) == op) legal = 1'b1;
        e = '{kind: 0, rw: 0, st: 0, cause: 0, lat: 0, instret: cnt};
        if (iw >= c_T) begin
            e.kind = 1; e.cause = 2; e.lat = c_T + 1;
        end else if (!legal) begin
            e.kind = 1; e.cause = 1; e.lat = iw + 3;
        end else if (op == 'h03 || op == 'h23) begin
            if (dw >= c_T) begin
                e.kind = 1; e.cause = 3; e.lat = iw + c_T + 4;
            end else if (op == 'h23) begin
                e.st = 1; e.lat = 4 + iw + dw;
            end else begin
                e.rw = 1; e.lat = 5 + iw + dw;
            end
        end else if (op == 'h63) begin
            e.lat = 3 + iw;
        end else begin
            e.rw = 1; e.lat = 4 + iw;
        end
        return e;
    endfunction

    // Memory responders: ack after the programmed number of wait cycles,
    // random noise on ack while no request is pending.
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            imem_ack = (i_cnt == i_delay);
            i_cnt++;
        end else begin
            imem_ack = ($urandom_range(0, 3) == 0);
            i_cnt    = 0;
        end
        if (dmem_req) begin
            dmem_ack = (d_cnt == d_delay);
            d_cnt++;
        end else begin
            dmem_ack = ($urandom_range(0, 3) == 0);
            d_cnt    = 0;
        end
    end

    // Monitor
    int         cyc = 0;
    int         start = 0;
    logic       prev_ireq = 1'b0;
    logic [2:0] prev_state = 3'd0;
    exp_t       m;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_ireq  = 1'b0;
            prev_state = 3'd0;
        end else begin
            if (imem_req && !prev_ireq) start = cyc;
            chk("ir_en", ir_en, imem_req & imem_ack);
            if (dmem_req) chk("dmem_we", dmem_we, opcode == 7'h23);
            if (pc_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    m = sb.pop_front();
                    chk("event_kind_retire", 0, m.kind);
                    chk("reg_write_en", reg_write_en, m.rw);
                    chk("store_retire", dmem_req & dmem_we, m.st);
                    chk("retire_latency", cyc - start + 1, m.lat);
                    chk("instret", instret, m.instret);
                end
                done++;
            end
            if (state == 3'd6 && prev_state != 3'd6) begin
                if (sb.size() == 0) begin
                    chk("unexpected_trap", 1, 0);
                end else begin
                    m = sb.pop_front();
                    chk("event_kind_trap", 1, m.kind);
                    chk("trap_cause", trap_cause, m.cause);
                    chk("trap_latency", cyc - start + 1, m.lat);
                    chk("halted", halted, 1);
                end
                done++;
            end
            prev_ireq  = imem_req;
            prev_state = state;
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic issue(input int op, input int iw, input int dw, input bit drop_run,
                         output exp_t e);
        e = model(op, iw, dw, model_instret);
        sb.push_back(e);
        issued++;
        if (e.kind == 0) model_instret = (model_instret + 1) % (1 << c_IW);
        i_delay = iw;
        d_delay = dw;
        @(posedge clk);
        #2;
        opcode = 7'(op);
        if (drop_run) run = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (done >= issued) break;
        end
        if (done < issued) begin
            chk("completion_timeout", done, issued);
            finish_run();
        end
    endtask

    task automatic handle_trap(input int cause, input int hold);
        repeat (hold) @(negedge clk);
        chk("trap_hold_state", state, 6);
        chk("trap_hold_cause", trap_cause, cause);
        chk("trap_hold_halted", halted, 1);
        chk("trap_strobes", {imem_req, dmem_req, reg_write_en, pc_en}, 0);
        #1 clear_trap = 1'b1;
        @(posedge clk);
        #1 clear_trap = 1'b0;
        @(negedge clk);
        chk("clear_state", state, 0);
        chk("clear_cause", trap_cause, 0);
        chk("clear_halted", halted, 0);
        chk("clear_instret", instret, model_instret);
    endtask

    exp_t e;
    int   op, iw, dw, r;

    initial begin
        rst = 1'b1; run = 1'b0; clear_trap = 1'b0; opcode = 7'h33;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_instret", instret, 0);
        chk("reset_cause", trap_cause, 0);
        chk("reset_halted", halted, 0);
        chk("reset_strobes", {imem_req, ir_en, dmem_req, reg_write_en, pc_en}, 0);

        #1 run = 1'b1;
        issue('h33, 0, 0, 1'b0, e);
        issue('h03, 0, 3, 1'b0, e);
        issue('h23, 0, 0, 1'b0, e);
        issue('h63, 0, 0, 1'b0, e);
        issue('h7F, 0, 0, 1'b0, e);
        handle_trap(1, 10);
        issue('h33, 30, 0, 1'b0, e);
        handle_trap(2, 2);
        issue('h33, c_T - 1, 0, 1'b0, e);
        issue('h03, 1, 30, 1'b0, e);
        handle_trap(3, 2);
        issue('h23, 1, c_T - 1, 1'b0, e);

        // run dropped mid-instruction: the load completes, then the sequencer idles
        issue('h03, 0, 2, 1'b1, e);
        repeat (3) @(negedge clk);
        chk("run0_idle_state", state, 0);
        chk("run0_no_fetch", imem_req, 0);
        #1 run = 1'b1;

        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? int'($urandom_range(0, 127)) : int'(legal_ops[$urandom_range(0, 8)]);
            r  = int'($urandom_range(0, 19));
            iw = (r == 0) ? 30 : r % c_T;
            r  = int'($urandom_range(0, 19));
            dw = (r == 0) ? 30 : r % c_T;
            issue(op, iw, dw, n == 399, e);
            if (e.kind == 1) handle_trap(e.cause, 2);
        end

        // reset while a data request is outstanding
        repeat (3) @(negedge clk);
        chk("pre_rst_idle", state, 0);
        #1;
        i_delay = 0; d_delay = 1000; run = 1'b1;
        @(posedge clk);
        #2 opcode = 7'h03;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dmem_req) break;
        end
        chk("mem_reached", dmem_req, 1);
        #1 run = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", state, 0);
        chk("rst_mid_dmem_req", dmem_req, 0);
        chk("rst_mid_instret", instret, 0);
        model_instret = 0;
        #1 run = 1'b1;
        issue('h13, 0, 0, 1'b1, e);
        repeat (2) @(negedge clk);
        chk("final_instret", instret, model_instret);
        chk("scoreboard_empty", sb.size(), 0);
        finish_run();
    end

endmodule
`default_nettype wire
